// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, free-running h/v counters, and sync/blank
// terms delayed to line up with the character painter's registered output.
module vga_timing_gen #(
    parameter int CLK_DIV    = 2,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIPE_DELAY = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_en,
    output logic [9:0] horzCoord,
    output logic [9:0] vertCoord,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       video_on,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 11-bit constants so that a 1024-wide total cannot silently truncate
    localparam logic [10:0] H_ACT_C  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SS_C   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SE_C   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST_C = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_ACT_C  = 11'(V_ACTIVE);
    localparam logic [10:0] V_SS_C   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SE_C   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] V_LAST_C = 11'(V_TOTAL - 1);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    // PIPE_DELAY = 0 still keeps one register so the outputs are glitch-free
    localparam int STAGES = (PIPE_DELAY == 0) ? 1 : PIPE_DELAY;

    logic [DIV_W-1:0] div;
    logic [10:0]      h_ext;
    logic [10:0]      v_ext;
    logic             h_last;
    logic             v_last;
    logic             hs_raw;
    logic             vs_raw;
    logic             vid_raw;
    logic [2:0]       dly [STAGES];

    assign h_ext  = {1'b0, horzCoord};
    assign v_ext  = {1'b0, vertCoord};
    assign h_last = (h_ext == H_LAST_C);
    assign v_last = (v_ext == V_LAST_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div    <= '0;
            pix_en <= 1'b0;
        end else begin
            pix_en <= (div == DIV_LAST);
            div    <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            horzCoord   <= '0;
            vertCoord   <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (pix_en) begin
                if (h_last) begin
                    horzCoord <= '0;
                    if (v_last) begin
                        vertCoord   <= '0;
                        frame_start <= 1'b1;
                    end else begin
                        vertCoord <= vertCoord + 10'd1;
                    end
                end else begin
                    horzCoord <= horzCoord + 10'd1;
                end
            end
        end
    end

    assign hs_raw  = !((h_ext >= H_SS_C) && (h_ext < H_SE_C));
    assign vs_raw  = !((v_ext >= V_SS_C) && (v_ext < V_SE_C));
    assign vid_raw = (h_ext < H_ACT_C) && (v_ext < V_ACT_C);

    // Runs every clk, not per pixel: the painter's pipeline latency is in clk cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) dly[i] <= 3'b110;
        end else begin
            dly[0] <= {hs_raw, vs_raw, vid_raw};
            for (int i = 1; i < STAGES; i++) dly[i] <= dly[i-1];
        end
    end

    assign {hsync_n, vsync_n, video_on} = dly[STAGES-1];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster (16x11) so whole frames fit in a short run;
// expectations come from a closed-form model indexed by clk edges since reset release.
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6, VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int D  = 2;

    typedef struct packed {
        logic       pix_en;
        logic [9:0] h;
        logic [9:0] v;
        logic       fs;
        logic       hs;
        logic       vs;
        logic       vid;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       pe3, hs3, vs3, vo3, fs3;
    logic       pe0, hs0, vs0, vo0, fs0;
    logic       pe1, hs1, vs1, vo1, fs1;
    logic [9:0] h3, v3, h0, v0, h1, v1;
    exp_t       obs3, obs0, obs1;

    assign obs3 = {pe3, h3, v3, fs3, hs3, vs3, vo3};
    assign obs0 = {pe0, h0, v0, fs0, hs0, vs0, vo0};
    assign obs1 = {pe1, h1, v1, fs1, hs1, vs1, vo1};

    vga_timing_gen #(.CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIPE_DELAY(3)) u_pd3 (
        .clk(clk), .rst_n(rst_n), .pix_en(pe3), .horzCoord(h3), .vertCoord(v3),
        .hsync_n(hs3), .vsync_n(vs3), .video_on(vo3), .frame_start(fs3));

    vga_timing_gen #(.CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIPE_DELAY(0)) u_pd0 (
        .clk(clk), .rst_n(rst_n), .pix_en(pe0), .horzCoord(h0), .vertCoord(v0),
        .hsync_n(hs0), .vsync_n(vs0), .video_on(vo0), .frame_start(fs0));

    vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIPE_DELAY(3)) u_div1 (
        .clk(clk), .rst_n(rst_n), .pix_en(pe1), .horzCoord(h1), .vertCoord(v1),
        .hsync_n(hs1), .vsync_n(vs1), .video_on(vo1), .frame_start(fs1));

    int   n_checks = 0;
    int   n_pass   = 0;
    int   t        = 0;
    exp_t q3[$], q0[$], q1[$];
    exp_t e3, e0, e1;
    exp_t rst_val;

    // Expected outputs after edge t; lat is the effective sync/blank latency in clk
    function automatic exp_t model(int tt, int d, int lat);
        exp_t e;
        int p, pd, hh, vv, td;
        p        = (tt >= 1) ? (tt - 1) / d : 0;
        e.pix_en = (tt >= d) && (tt % d == 0);
        e.h      = 10'(p % HT);
        e.v      = 10'((p / HT) % VT);
        e.fs     = (p > 0) && (p % (HT * VT) == 0) && ((tt - 1) % d == 0);
        td       = tt - lat;
        if (td < 0) begin
            e.hs = 1'b1; e.vs = 1'b1; e.vid = 1'b0;
        end else begin
            pd    = (td >= 1) ? (td - 1) / d : 0;
            hh    = pd % HT;
            vv    = (pd / HT) % VT;
            e.hs  = !(hh >= HA + HF && hh < HA + HF + HS);
            e.vs  = !(vv >= VA + VF && vv < VA + VF + VS);
            e.vid = (hh < HA) && (vv < VA);
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        t++;
        q3.push_back(model(t, D, 3));
        q0.push_back(model(t, D, 1));
        q1.push_back(model(t, 1, 3));
        @(negedge clk);
        e3 = q3.pop_front();
        e0 = q0.pop_front();
        e1 = q1.pop_front();
    endtask

    task automatic test_reset();
        rst_val = '{pix_en: 1'b0, h: 10'd0, v: 10'd0, fs: 1'b0, hs: 1'b1, vs: 1'b1, vid: 1'b0};
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (obs3 !== rst_val) $display("FAIL reset_pd3: got %h expected %h", obs3, rst_val); else n_pass++;
        n_checks++; if (obs0 !== rst_val) $display("FAIL reset_pd0: got %h expected %h", obs0, rst_val); else n_pass++;
        n_checks++; if (obs1 !== rst_val) $display("FAIL reset_div1: got %h expected %h", obs1, rst_val); else n_pass++;
    endtask

    task automatic test_divider();
        rst_n = 1'b1;
        t = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++; if (obs3 !== e3) $display("FAIL div_pd3 t=%0d: got %h expected %h", t, obs3, e3); else n_pass++;
            n_checks++; if (obs0 !== e0) $display("FAIL div_pd0 t=%0d: got %h expected %h", t, obs0, e0); else n_pass++;
            n_checks++; if (obs1 !== e1) $display("FAIL div_div1 t=%0d: got %h expected %h", t, obs1, e1); else n_pass++;
        end
    endtask

    task automatic test_line_wrap();
        int fall3 = -1, rise3 = -1, fall0 = -1;
        int wrap_v = -1;
        logic prev3 = hs3, prev0 = hs0;
        while (t < 60) begin
            tick();
            n_checks++; if (obs3 !== e3) $display("FAIL line_pd3 t=%0d: got %h expected %h", t, obs3, e3); else n_pass++;
            n_checks++; if (obs0 !== e0) $display("FAIL line_pd0 t=%0d: got %h expected %h", t, obs0, e0); else n_pass++;
            if (prev3 && !hs3 && fall3 < 0) fall3 = t;
            if (!prev3 && hs3 && rise3 < 0 && fall3 >= 0) rise3 = t;
            if (prev0 && !hs0 && fall0 < 0) fall0 = t;
            if (t == HT * D + 1) wrap_v = (h3 == 10'd0) ? int'(v3) : -1;
            prev3 = hs3;
            prev0 = hs0;
        end
        n_checks++; if (fall3 != (HA + HF) * D + 1 + 3) $display("FAIL hsync_fall_pd3: got %0d expected %0d", fall3, (HA + HF) * D + 4); else n_pass++;
        n_checks++; if (fall0 != (HA + HF) * D + 1 + 1) $display("FAIL hsync_fall_pd0: got %0d expected %0d", fall0, (HA + HF) * D + 2); else n_pass++;
        n_checks++; if (rise3 - fall3 != HS * D) $display("FAIL hsync_width: got %0d expected %0d", rise3 - fall3, HS * D); else n_pass++;
        n_checks++; if (wrap_v != 1) $display("FAIL line_wrap_v: got %0d expected 1", wrap_v); else n_pass++;
    endtask

    task automatic test_delay_align();
        int vf0 = -1, vf3 = -1, hf0 = -1, hf3 = -1;
        logic pv0 = vo0, pv3 = vo3, ph0 = hs0, ph3 = hs3;
        while (t < 100) begin
            tick();
            n_checks++; if (obs3 !== e3) $display("FAIL align_pd3 t=%0d: got %h expected %h", t, obs3, e3); else n_pass++;
            n_checks++; if (obs0 !== e0) $display("FAIL align_pd0 t=%0d: got %h expected %h", t, obs0, e0); else n_pass++;
            if (pv0 && !vo0 && vf0 < 0) vf0 = t;
            if (pv3 && !vo3 && vf3 < 0 && vf0 >= 0) vf3 = t;
            if (ph0 && !hs0 && hf0 < 0) hf0 = t;
            if (ph3 && !hs3 && hf3 < 0 && hf0 >= 0) hf3 = t;
            pv0 = vo0; pv3 = vo3; ph0 = hs0; ph3 = hs3;
        end
        n_checks++; if (vf0 < 0 || vf3 - vf0 != 2) $display("FAIL video_shift: got %0d expected 2", vf3 - vf0); else n_pass++;
        n_checks++; if (hf0 < 0 || hf3 - hf0 != 2) $display("FAIL hsync_shift: got %0d expected 2", hf3 - hf0); else n_pass++;
    endtask

    task automatic test_frame_wrap();
        int fs_t[$];
        int vid_cnt = 0, vs_cnt = 0, hs_cnt = 0;
        int frame = HT * VT * D;
        while (t < 2 * frame + 8) begin
            tick();
            n_checks++; if (obs3 !== e3) $display("FAIL frame_pd3 t=%0d: got %h expected %h", t, obs3, e3); else n_pass++;
            n_checks++; if (obs1 !== e1) $display("FAIL frame_div1 t=%0d: got %h expected %h", t, obs1, e1); else n_pass++;
            if (fs3) fs_t.push_back(t);
            if (t > frame && t <= 2 * frame) begin
                if (vo3)  vid_cnt++;
                if (!vs3) vs_cnt++;
                if (!hs3) hs_cnt++;
            end
        end
        n_checks++; if (fs_t.size() != 2) $display("FAIL frame_start_count: got %0d expected 2", fs_t.size()); else n_pass++;
        if (fs_t.size() == 2) begin
            n_checks++; if (fs_t[0] != frame + 1) $display("FAIL frame_start_time: got %0d expected %0d", fs_t[0], frame + 1); else n_pass++;
            n_checks++; if (fs_t[1] - fs_t[0] != frame) $display("FAIL frame_period: got %0d expected %0d", fs_t[1] - fs_t[0], frame); else n_pass++;
        end
        n_checks++; if (vid_cnt != HA * VA * D) $display("FAIL video_count: got %0d expected %0d", vid_cnt, HA * VA * D); else n_pass++;
        n_checks++; if (vs_cnt != VS * HT * D) $display("FAIL vsync_count: got %0d expected %0d", vs_cnt, VS * HT * D); else n_pass++;
        n_checks++; if (hs_cnt != HS * D * VT) $display("FAIL hsync_count: got %0d expected %0d", hs_cnt, HS * D * VT); else n_pass++;
    endtask

    task automatic test_async_reset();
        int   budget = 0;
        int   fs_cnt = 0;
        while (!(h3 == 10'd5 && v3 == 10'd3) && budget < 400) begin
            tick();
            budget++;
        end
        n_checks++; if (budget >= 400) $display("FAIL midline_reach: got h=%0d v=%0d expected h=5 v=3", h3, v3); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (obs3 !== rst_val) $display("FAIL async_rst_pd3: got %h expected %h", obs3, rst_val); else n_pass++;
        n_checks++; if (obs0 !== rst_val) $display("FAIL async_rst_pd0: got %h expected %h", obs0, rst_val); else n_pass++;
        n_checks++; if (obs1 !== rst_val) $display("FAIL async_rst_div1: got %h expected %h", obs1, rst_val); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (fs3 || fs0 || fs1) fs_cnt++;
            n_checks++; if (obs3 !== e3) $display("FAIL restart_pd3 t=%0d: got %h expected %h", t, obs3, e3); else n_pass++;
            n_checks++; if (obs1 !== e1) $display("FAIL restart_div1 t=%0d: got %h expected %h", t, obs1, e1); else n_pass++;
        end
        n_checks++; if (fs_cnt != 0) $display("FAIL restart_frame_start: got %0d expected 0", fs_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_divider();
        test_line_wrap();
        test_delay_align();
        test_frame_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
